// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux scan controller.
// Optional parity output is enabled in mux_scan_ctrl by defining MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } scan_state_t;

  typedef struct packed {
    logic             none;
    logic [SEL_W-1:0] ch;
  } next_ch_t;

  // Next enabled channel strictly above cur; none=1 when no higher channel is enabled.
  function automatic next_ch_t next_enabled(input logic [NCH-1:0] mask,
                                            input logic [SEL_W-1:0] cur);
    next_ch_t     r;
    int unsigned  idx;
    r.none = 1'b1;
    r.ch   = cur;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = NCH - 1 - i;
      if ((idx > 32'(cur)) && mask[idx]) begin
        r.none = 1'b0;
        r.ch   = SEL_W'(idx);
      end
    end
    return r;
  endfunction

  // Lowest enabled channel; none=1 for an all-zero mask.
  function automatic next_ch_t first_enabled(input logic [NCH-1:0] mask);
    next_ch_t r;
    if (mask[0]) begin
      r.none = 1'b0;
      r.ch   = '0;
    end else begin
      r = next_enabled(mask, '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell.sv
// Dwell counter for mux_scan_ctrl: counts 0..DWELL-1 while enabled, flags the last cycle.
module scan_dwell_cnt #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned     CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   LAST_V = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == LAST_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: sweeps enabled channels, captures mux_out, hands the word off on valid/ready.
// Define MUX_SCAN_PARITY_EN to add the registered sample_par output.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NCH-1:0]   en_mask,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   sample,
  output logic             sample_valid,
  input  logic             sample_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic             sample_par,
`endif
  output logic             busy
);

  scan_state_t      state_q, state_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NCH-1:0]   sample_q, sample_d;
  logic             cnt_clr, cnt_en, cnt_last;
  next_ch_t         first_ch, next_ch;

  scan_dwell_cnt #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  assign first_ch = first_enabled(en_mask);
  assign next_ch  = next_enabled(mask_q, sel_q);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    sel_d    = sel_q;
    sample_d = sample_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        sel_d   = '0;
        if (start) begin
          mask_d   = en_mask;
          sample_d = '0;
          // Decide on en_mask directly: it is the value being latched into mask_q this edge.
          if (!first_ch.none) begin
            state_d = SCAN;
            sel_d   = first_ch.ch;
          end else begin
            state_d = HOLD;
          end
        end
      end
      SCAN: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          sample_d[sel_q] = mux_out;
          if (next_ch.none) begin
            state_d = HOLD;
          end else begin
            sel_d = next_ch.ch;
          end
        end
      end
      HOLD: begin
        if (sample_ready) begin
          state_d = IDLE;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      sel_q    <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      sel_q    <= sel_d;
      sample_q <= sample_d;
    end
  end

  assign sel          = sel_q;
  assign sample       = sample_q;
  assign sample_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^sample_d;
    end
  end

  assign sample_par = par_q;
`endif

endmodule
